// File: rtl/instr_fetch_pkg.sv
// Shared jacaranda-8 defines: datapath widths, fetch defaults and small helpers
// used by the fetch unit, decoder and core.
package instr_fetch_pkg;

  localparam int XLEN          = 8;
  localparam int DROP_W        = 8;
  localparam int BUF_DEPTH_DEF = 2;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t RESET_PC_DEF = 8'h00;

  typedef struct packed {
    logic  valid;
    word_t data;
  } imem_rsp_t;

  function automatic word_t pc_next(input word_t pc);
    return pc + word_t'(1);
  endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// Instruction buffer between the memory response port and decode.
// Power-of-two depth so the pointers wrap for free; flush empties it in one cycle.
module fetch_fifo #(
  parameter  int DEPTH = 2,
  parameter  int DW    = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [DW-1:0] pop_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [DEPTH-1:0][DW-1:0] mem;
  logic [PW-1:0]            wr_ptr;
  logic [PW-1:0]            rd_ptr;
  logic                     do_push;
  logic                     do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop & ~empty;
  // A full buffer still takes a push when the head leaves in the same cycle.
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// In-order instruction fetch: issues byte fetches, buffers responses for decode,
// and squashes in-flight responses after a redirect.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter int              BUF_DEPTH = BUF_DEPTH_DEF
) (
  input  logic            clock,
  input  logic            reset_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam int SW = CW + 1;

  logic            run;
  word_t           fetch_pc;
  word_t           deliver_pc;
  logic [CW-1:0]   outstanding;
  logic [DROP_W-1:0] drop_cnt;

  imem_rsp_t       rsp;
  logic            gnt_fire;
  logic            rsp_drop;
  logic            rsp_acc;
  logic            rsp_used;
  logic            push;
  logic            pop;
  logic [SW-1:0]   in_flight;

  logic [CW-1:0]   buf_count;
  logic            buf_full;
  logic            buf_empty;
  word_t           buf_head;

  assign rsp = '{valid: imem_rvalid, data: imem_rdata};

  // run holds requests off until the first edge after reset release.
  assign in_flight = SW'(outstanding) + SW'(buf_count);
  assign imem_req  = run & ~redirect & (in_flight < SW'(BUF_DEPTH));
  assign imem_addr = fetch_pc;
  assign gnt_fire  = imem_req & imem_gnt;

  // Stale responses are consumed first; an rvalid with nothing owed is ignored.
  assign rsp_drop  = rsp.valid & (drop_cnt != '0);
  assign rsp_acc   = rsp.valid & (drop_cnt == '0) & (outstanding != '0);
  assign rsp_used  = rsp_drop | rsp_acc;
  assign push      = rsp_acc & ~redirect & (~buf_full | pop);

  assign instr_valid = ~buf_empty & ~redirect;
  assign instr       = buf_head;
  assign instr_pc    = deliver_pc;
  assign pop         = instr_valid & instr_ready;

  fetch_fifo #(
    .DEPTH (BUF_DEPTH),
    .DW    (XLEN)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (rsp.data),
    .pop       (pop),
    .flush     (redirect),
    .pop_data  (buf_head),
    .full      (buf_full),
    .empty     (buf_empty),
    .count     (buf_count)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run         <= 1'b0;
      fetch_pc    <= RESET_PC;
      deliver_pc  <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      run <= 1'b1;
      if (redirect) begin
        fetch_pc    <= redirect_pc;
        deliver_pc  <= redirect_pc;
        outstanding <= '0;
        // Everything still owed by memory becomes stale, including drops
        // left over from an earlier redirect.
        drop_cnt    <= drop_cnt + DROP_W'(outstanding) - DROP_W'(rsp_used);
      end else begin
        if (gnt_fire) fetch_pc   <= pc_next(fetch_pc);
        if (pop)      deliver_pc <= pc_next(deliver_pc);
        outstanding <= outstanding + CW'(gnt_fire) - CW'(rsp_acc);
        if (rsp_drop) drop_cnt <= drop_cnt - DROP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: in-order memory model, scoreboard of granted PCs,
// a vector table of redirect scenarios and hand-written corner sequences.
module tb_instr_fetch;

  localparam int         DEPTH = 4;
  localparam logic [7:0] RPC   = 8'h00;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_gnt = 1'b0;
  logic       imem_rvalid = 1'b0;
  logic [7:0] imem_rdata = 8'h00;
  logic       instr_valid;
  logic [7:0] instr;
  logic [7:0] instr_pc;
  logic       instr_ready = 1'b0;
  logic       redirect = 1'b0;
  logic [7:0] redirect_pc = 8'h00;

  always #5 clock = ~clock;

  instr_fetch #(.RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  typedef struct { logic [7:0] addr; int due; } mreq_t;
  typedef struct {
    logic [7:0] tgt;
    int lat_max; int gnt_pct; int rdy_pct; int ncyc; int min_deliv;
  } vec_t;

  mreq_t      mq[$];
  logic [7:0] eq[$];
  int         lf[$];
  int errors = 0, checks = 0, cyc = 0, n_deliv = 0, n_grant = 0;
  int gnt_pct = 100, rdy_pct = 100, lat_min = 1, lat_max = 1, redir_pct = 0;
  logic [7:0] mf = RPC;
  logic [7:0] first_pc = 8'h00;
  bit         got_first = 1'b0;
  bit         prev_hold = 1'b0;
  logic [7:0] prev_instr, prev_pc;
  vec_t       tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, sample outputs before the edge, update model.
  task automatic step(input bit redir = 1'b0, input logic [7:0] tgt = 8'h00,
                      input bit spurious = 1'b0);
    bit g, rdy, rv;
    int lat;
    logic [7:0] e;
    if (!redir && redir_pct > 0 && $urandom_range(0, 99) < redir_pct) begin
      redir = 1'b1;
      tgt   = 8'($urandom);
    end
    g   = $urandom_range(0, 99) < gnt_pct;
    rdy = $urandom_range(0, 99) < rdy_pct;
    rv  = spurious || (mq.size() > 0 && mq[0].due <= cyc);
    redirect    = redir;
    redirect_pc = tgt;
    imem_gnt    = g;
    instr_ready = rdy;
    imem_rvalid = rv;
    imem_rdata  = (!spurious && mq.size() > 0) ? (mq[0].addr ^ 8'hA5) : 8'h3C;
    #1;
    if (redir) begin
      chk("redir_req", imem_req, 0);
      chk("redir_valid", instr_valid, 0);
    end else begin
      if (prev_hold) begin
        chk("hold_valid", instr_valid, 1);
        chk("hold_instr", instr, prev_instr);
        chk("hold_pc", instr_pc, prev_pc);
      end
      if (imem_req && g) begin
        chk("fetch_addr", imem_addr, mf);
        lat = (lf.size() > 0) ? lf.pop_front() : $urandom_range(lat_min, lat_max);
        mq.push_back('{imem_addr, cyc + lat});
        eq.push_back(mf);
        mf = mf + 8'd1;
        n_grant++;
      end
      if (instr_valid && rdy) begin
        if (eq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_instr: got pc %0h, none expected (cycle %0d)", instr_pc, cyc);
        end else begin
          e = eq.pop_front();
          chk("instr_pc", instr_pc, e);
          chk("instr", instr, e ^ 8'hA5);
          if (!got_first) begin got_first = 1'b1; first_pc = instr_pc; end
          n_deliv++;
        end
      end
      chk("occupancy", 32'(eq.size() > DEPTH), 0);
    end
    prev_hold  = !redir && instr_valid && !rdy;
    prev_instr = instr;
    prev_pc    = instr_pc;
    if (redir) begin eq.delete(); mf = tgt; got_first = 1'b0; end
    if (rv && !spurious) void'(mq.pop_front());
    @(posedge clock);
    cyc++;
    #1;
  endtask

  task automatic drain();
    gnt_pct = 0; rdy_pct = 100; redir_pct = 0;
    for (int i = 0; i < 60 && (mq.size() > 0 || eq.size() > 0); i++) step();
    step(); step();
    chk("drained", mq.size() + eq.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"}, imem_req, 0);
    chk({tag, "_addr"}, imem_addr, RPC);
    chk({tag, "_valid"}, instr_valid, 0);
    chk({tag, "_instr"}, instr, 0);
    chk({tag, "_pc"}, instr_pc, RPC);
  endtask

  initial begin
    int d, g0;
    tbl[0] = '{8'hFE, 1, 100, 100, 20, 14};
    tbl[1] = '{8'h40, 3, 100, 100, 30, 10};
    tbl[2] = '{8'h7F, 5,  70,  60, 60,  5};
    tbl[3] = '{8'hC3, 2,  50, 100, 40,  5};
    tbl[4] = '{8'h00, 5, 100,  30, 60,  5};

    // Reset and release: requests start only after the first edge.
    #1 reset_n = 1'b0;
    #2 check_reset_outputs("reset");
    @(posedge clock); @(posedge clock); #1;
    reset_n = 1'b1;
    #1 chk("req_before_edge", imem_req, 0);
    cyc = 0;
    step();
    chk("first_req", imem_req, 1);

    // Streaming with 1-cycle memory: one instruction per cycle after fill.
    for (int i = 0; i < 30; i++) begin
      if (i == 10) d = n_deliv;
      step();
    end
    chk("throughput", n_deliv - d, 20);
    chk("stream_first_pc", {got_first, first_pc}, {1'b1, RPC});

    // Decode stall: grants bounded by buffer depth, head held stable.
    rdy_pct = 0; g0 = n_grant;
    for (int i = 0; i < 10; i++) step();
    chk("stall_grants", 32'(n_grant - g0 <= DEPTH), 1);
    rdy_pct = 100;
    for (int i = 0; i < 10; i++) step();
    drain();

    // Redirect scenario table.
    for (int i = 0; i < 5; i++) begin
      lat_min = 1; lat_max = tbl[i].lat_max;
      gnt_pct = tbl[i].gnt_pct; rdy_pct = tbl[i].rdy_pct;
      step(1'b1, tbl[i].tgt);
      d = n_deliv;
      for (int c = 0; c < tbl[i].ncyc; c++) step();
      chk("tbl_first_pc", {got_first, first_pc}, {1'b1, tbl[i].tgt});
      chk("tbl_min_deliv", 32'(n_deliv - d >= tbl[i].min_deliv), 1);
    end
    drain();

    // Redirect with two in flight; stale data returns 1 and 3 cycles later.
    lat_min = 1; lat_max = 1; gnt_pct = 100; rdy_pct = 100;
    lf.push_back(3); lf.push_back(4);
    step(); step();
    step(1'b1, 8'h40);
    for (int i = 0; i < 12; i++) step();
    chk("drop_first_pc", {got_first, first_pc}, {1'b1, 8'h40});
    drain();

    // Back-to-back redirects: the later target wins.
    gnt_pct = 100; lat_max = 2;
    step(1'b1, 8'h10);
    step(1'b1, 8'h20);
    for (int i = 0; i < 12; i++) step();
    chk("b2b_first_pc", {got_first, first_pc}, {1'b1, 8'h20});
    drain();

    // Unsolicited response must be ignored.
    d = n_deliv;
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) step();
    chk("spurious_quiet", n_deliv - d, 0);
    gnt_pct = 100; lat_max = 1;
    for (int i = 0; i < 8; i++) step();
    drain();

    // Random traffic with random redirects.
    lat_min = 1; lat_max = 5;
    for (int i = 0; i < 1500; i++) begin
      gnt_pct = 60; rdy_pct = 60; redir_pct = 3;
      step();
    end
    redir_pct = 0;
    drain();

    // Mid-stream reset with two outstanding requests.
    gnt_pct = 100; rdy_pct = 0; lat_min = 4; lat_max = 4;
    step(); step();
    reset_n = 1'b0;
    #1 check_reset_outputs("midreset");
    mq.delete(); eq.delete(); lf.delete();
    mf = RPC; got_first = 1'b0; prev_hold = 1'b0;
    imem_rvalid = 1'b0; imem_gnt = 1'b0;
    @(posedge clock); @(posedge clock); #1;
    reset_n = 1'b1;
    lat_min = 1; lat_max = 1; rdy_pct = 100;
    for (int i = 0; i < 20; i++) step();
    chk("restart_first_pc", {got_first, first_pc}, {1'b1, RPC});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 8'h00: PC loaded at reset.
REQ-002 Parameter BUF_DEPTH, default 2: instruction buffer depth and maximum in-flight request count (legal values 2 or 4).
REQ-003 clock  input  1  single clock; all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 imem_req  output  1  fetch request valid.
REQ-006 imem_addr  output  8  fetch address; meaningful only while imem_req=1.
REQ-007 imem_gnt  input  1  request accepted in any cycle with imem_req & imem_gnt.
REQ-008 imem_rvalid  input  1  read data valid; responses return in request order, latency >=1 cycle after grant.
REQ-009 imem_rdata  input  8  instruction byte.
REQ-010 instr_valid  output  1  instr/instr_pc valid toward the decode stage.
REQ-011 instr  output  8  instruction byte for the decoder.
REQ-012 instr_pc  output  8  address of instr.
REQ-013 instr_ready  input  1  decode consumes the instruction in any cycle with instr_valid & instr_ready.
REQ-014 redirect  input  1  branch/jump taken; discard all sequential fetch state.
REQ-015 redirect_pc  input  8  new fetch target, sampled when redirect=1.

Function
REQ-016 fetch_pc: advances by 1 on each grant, 8'hFF wraps to 8'h00; imem_addr = fetch_pc.
REQ-017 outstanding: +1 on grant, -1 on accepted (non-dropped) response; +1 and -1 in the same cycle leaves it unchanged.
REQ-018 imem_req = 1 iff (outstanding + buffer occupancy) < BUF_DEPTH and redirect=0; buffer overflow is therefore impossible.
REQ-019 imem_req is Moore-style: it does not depend combinationally on imem_gnt.
REQ-020 A non-dropped response pushes imem_rdata into the buffer tail; instr_valid rises the next cycle (rvalid-to-instr_valid latency = 1).
REQ-021 instr and instr_valid come from the buffer head; instr_pc = deliver_pc.
REQ-022 deliver_pc: +1 (wrapping) on each decode handshake.
REQ-023 A push and a pop in the same cycle are both performed, with occupancy unchanged.
REQ-024 Buffer empty: instr_valid=0. While instr_ready=0, instr and instr_pc hold stable.
REQ-025 Redirect cycle: instr_valid and imem_req forced to 0.
REQ-026 Redirect next state: buffer emptied; fetch_pc and deliver_pc <= redirect_pc; drop_cnt <= outstanding (minus 1 if a response arrives that cycle, which is itself discarded); outstanding <= 0.
REQ-027 While drop_cnt>0, each imem_rvalid decrements drop_cnt and is discarded; it is never pushed and never decrements outstanding.
REQ-028 New requests may issue while drop_cnt>0; their responses are accepted only after drop_cnt reaches 0, which ordering guarantees.
REQ-029 Back-to-back redirects: each takes effect, and the last one defines the PC.
REQ-030 imem_rvalid with outstanding=0 and drop_cnt=0 is a protocol error and is ignored, with no state change.

Reset
REQ-031 reset_n=0 asynchronously clears the buffer, outstanding and drop_cnt, and sets fetch_pc and deliver_pc to RESET_PC.
REQ-032 Outputs while reset_n=0: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=8'h00, instr_pc=RESET_PC.
REQ-033 First imem_req=1 occurs in the first clock edge after reset release.
REQ-034 A reset asserted mid-fetch abandons in-flight responses; the memory side is reset concurrently.

Structure
REQ-035 RESET_PC default, the 8-bit PC/instruction widths and BUF_DEPTH default belong in the shared jacaranda-8 defines header, shared with the decoder and core.
REQ-036 The buffer is one sub-module, fetch_fifo: parameterised depth, 8-bit data, push/pop/flush, and full/empty/count outputs.
REQ-037 Counters and control logic live in instr_fetch.

Verification
REQ-038 Reset release; gnt=1; rdata=addr^8'hA5 at 1-cycle latency; ready=1 -> instr_pc 00,01,02... consecutive, instr=pc^A5, one instr per cycle after fill.
REQ-039 ready=0 for 10 cycles -> at most BUF_DEPTH grants; instr and instr_pc held stable; no response lost when ready returns.
REQ-040 Redirect to 8'h40 with 2 outstanding; responses arrive 1 and 3 cycles later -> both dropped; next delivered instr_pc=40 with data from addr 40.
REQ-041 fetch_pc=FE, continuous run -> addresses FE, FF, 00, 01; instr_pc wraps identically.
REQ-042 Random gnt/rvalid latency (1-5 cycles) and random ready/redirect -> the delivered stream matches a reference-model PC sequence; the buffer never overflows.
REQ-043 reset_n asserted mid-stream with 2 outstanding -> outputs take reset values immediately (asynchronously); fetch restarts at RESET_PC.
